// File: rtl/adder_pkg.sv
// Shared types and defaults for the adder datapath slice.
package adder_pkg;

  localparam int ADDER_N = 4;

  // One adder result as it sits in the result FIFO.
  typedef struct packed {
    logic [ADDER_N-1:0] sum;
    logic               cout;
  } adder_res_t;

  // Occupancy of the operand register.
  typedef enum logic {
    OP_EMPTY = 1'b0,
    OP_FULL  = 1'b1
  } op_state_t;

endpackage

// File: rtl/adder_result_fifo.sv
// Small synchronous FIFO for adder results.
// When empty, the output holds the last popped head (or the reset value).
module adder_result_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [W-1:0]               i_wdata,
  output logic [W-1:0]               o_rdata,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [W-1:0]  r_last;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_count   = r_count;
  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !o_empty;
  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_rdata   = o_empty ? r_last : r_mem[r_rd_ptr];

  // Storage, pointers, occupancy and the last-popped head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_last   <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_last   <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/adder_io_stage.sv
// Registered valid/ready shell around an external combinational adder:
// operand register feeding the adder, result FIFO capturing its output,
// and a saturating carry-out event counter.
module adder_io_stage
  import adder_pkg::*;
#(
  parameter int N     = ADDER_N,
  parameter int DEPTH = 2,
  parameter int CW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_a,
  input  logic [N-1:0]  in_b,
  output logic [N-1:0]  add_a,
  output logic [N-1:0]  add_b,
  input  logic [N-1:0]  add_x,
  input  logic          add_cout,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_sum,
  output logic          out_cout,
  output logic [CW-1:0] cout_cnt,
  input  logic          clr_cnt
);

  op_state_t              r_state;
  logic [N-1:0]           r_add_a;
  logic [N-1:0]           r_add_b;
  logic [CW-1:0]          r_cout_cnt;
  logic                   w_op_valid;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_accept;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  logic [$clog2(DEPTH):0] w_fifo_count;
  logic [N:0]             w_rdata;

  assign w_op_valid = (r_state == OP_FULL);
  assign w_pop      = !w_fifo_empty && out_ready;
  assign w_push     = w_op_valid && (!w_fifo_full || w_pop);
  // Depends only on state and out_ready, never on in_valid.
  assign in_ready   = !w_op_valid || w_push;
  assign w_accept   = in_valid && in_ready;

  assign add_a      = r_add_a;
  assign add_b      = r_add_b;
  assign out_valid  = !w_fifo_empty;
  assign out_sum    = w_rdata[N:1];
  assign out_cout   = w_rdata[0];
  assign cout_cnt   = r_cout_cnt;

  // Operand register FSM: load on accept, empty on push, hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= OP_EMPTY;
      r_add_a <= '0;
      r_add_b <= '0;
    end else begin
      case (r_state)
        OP_EMPTY: begin
          if (w_accept) begin
            r_state <= OP_FULL;
            r_add_a <= in_a;
            r_add_b <= in_b;
          end
        end
        OP_FULL: begin
          if (w_accept) begin
            r_add_a <= in_a;
            r_add_b <= in_b;
          end else if (w_push) begin
            r_state <= OP_EMPTY;
          end
        end
        default: r_state <= OP_EMPTY;
      endcase
    end
  end

  // Carry-out event counter: clear wins, otherwise saturating increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cout_cnt <= '0;
    end else if (clr_cnt) begin
      r_cout_cnt <= '0;
    end else if (w_push && add_cout && (r_cout_cnt != '1)) begin
      r_cout_cnt <= r_cout_cnt + 1'b1;
    end
  end

  adder_result_fifo #(
    .DEPTH (DEPTH),
    .W     (N + 1)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata ({add_x, add_cout}),
    .o_rdata (w_rdata),
    .o_count (w_fifo_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

endmodule
